// File: rtl/gf7_pkg.sv
// Shared types and constants for the GF(2^7) inverter (field polynomial x^7 + x + 1).
package gf7_pkg;

  localparam int unsigned GF_W        = 7;
  localparam logic [7:0]  GF_POLY     = 8'h83;
  localparam int unsigned CHAIN_STEPS = 5;

  typedef logic [GF_W-1:0] gf7_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQR  = 3'd1,
    MUL  = 3'd2,
    FSQ  = 3'd3,
    DONE = 3'd4
  } inv_state_t;

endpackage

// File: rtl/gf7_mul.sv
// Combinational GF(2^7) multiplier: p = a*b mod x^7 + x + 1.
module gf7_mul
  import gf7_pkg::*;
(
  input  gf7_t a_i,
  input  gf7_t b_i,
  output gf7_t p_o
);

  localparam gf7_t RED = GF_POLY[GF_W-1:0];

  // Shift-and-add: each step multiplies the running multiplicand by x and reduces it.
  always_comb begin
    gf7_t acc;
    gf7_t mc;
    acc = '0;
    mc  = a_i;
    for (int i = 0; i < int'(GF_W); i++) begin
      if (b_i[i]) acc = acc ^ mc;
      mc = {mc[GF_W-2:0], 1'b0} ^ (mc[GF_W-1] ? RED : gf7_t'(0));
    end
    p_o = acc;
  end

endmodule

// File: rtl/gf7_inv_seq.sv
// Sequential GF(2^7) inverter: a^-1 = a^126 via five (square, multiply) rounds and a final square,
// sharing a single combinational multiplier.
module gf7_inv_seq
  import gf7_pkg::*;
#(
  parameter int unsigned W = GF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_inv,
  output logic         out_zero
);

  localparam logic [2:0] K_LAST = 3'(CHAIN_STEPS - 1);

  inv_state_t state_q, state_d;
  gf7_t       t_q, t_d;
  gf7_t       a_q, a_d;
  logic [2:0] k_q, k_d;
  logic       zero_q, zero_d;
  logic       in_ready_q, out_valid_q;
  gf7_t       mul_b;
  gf7_t       prod;

  // Operand mux: only MUL pulls in the original operand, every other step squares t.
  assign mul_b = (state_q == MUL) ? a_q : t_q;

  gf7_mul u_mul (
    .a_i (t_q),
    .b_i (mul_b),
    .p_o (prod)
  );

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    k_d     = k_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          t_d     = in_a;
          k_d     = 3'd0;
          zero_d  = (in_a == '0);
          state_d = SQR;
        end
      end
      SQR: begin
        t_d     = prod;
        state_d = MUL;
      end
      MUL: begin
        t_d = prod;
        if (k_q == K_LAST) begin
          state_d = FSQ;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = SQR;
        end
      end
      FSQ: begin
        t_d     = prod;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      a_q         <= '0;
      k_q         <= 3'd0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      a_q         <= a_d;
      k_q         <= k_d;
      zero_q      <= zero_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_inv   = t_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_gf7_inv_seq.sv
// Directed and sweep checks for gf7_inv_seq against an independent carry-less multiply model.
module tb_gf7_inv_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_a;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_inv;
  logic       out_zero;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gf7_inv_seq #(.W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inv   (out_inv),
    .out_zero  (out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full 13-bit carry-less product, then fold bits 12..7 down with x^7 = x + 1.
  function automatic logic [6:0] ref_mul(input logic [6:0] a, input logic [6:0] b);
    logic [12:0] p;
    p = 13'd0;
    for (int i = 0; i < 7; i++)
      if (b[i]) p = p ^ (13'(a) << i);
    for (int i = 12; i >= 7; i--)
      if (p[i]) p = p ^ (13'h083 << (i - 7));
    return p[6:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation; stall>0 holds out_ready low that many cycles after out_valid rises.
  task automatic do_op(input logic [6:0] a, input int stall, input bit extra,
                       output logic [6:0] inv, output logic zero, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = a;
    out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    if (lat >= 50) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      inv  = 7'h00;
      zero = 1'b0;
      return;
    end
    inv  = out_inv;
    zero = out_zero;
    for (int s = 0; s < stall; s++) begin
      if (extra) begin
        in_valid = 1'b1;
        in_a     = 7'h05;
      end
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_inv", 32'(out_inv), 32'(inv));
      chk("hold_zero", 32'(out_zero), 32'(zero));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [6:0] inv;
    logic       zero;
    int         lat;
    int         results;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 7'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inv", 32'(out_inv), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);

    do_op(7'h02, 0, 1'b0, inv, zero, lat);
    chk("a02_inv", 32'(inv), 32'h41);
    chk("a02_zero", 32'(zero), 32'd0);
    chk("a02_lat", 32'(lat), 32'd11);

    do_op(7'h41, 0, 1'b0, inv, zero, lat);
    chk("a41_inv", 32'(inv), 32'h02);
    do_op(7'h01, 0, 1'b0, inv, zero, lat);
    chk("a01_inv", 32'(inv), 32'h01);

    do_op(7'h00, 0, 1'b0, inv, zero, lat);
    chk("a00_inv", 32'(inv), 32'h00);
    chk("a00_zero", 32'(zero), 32'd1);
    chk("a00_lat", 32'(lat), 32'd11);

    // Backpressure with a competing operand offered during the stall.
    do_op(7'h02, 6, 1'b1, inv, zero, lat);
    chk("bp_inv", 32'(inv), 32'h41);
    chk("bp_lat", 32'(lat), 32'd11);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("bp_no_extra_result", 32'(out_valid), 32'd0);
    end

    // Reset mid-operation discards the operand.
    in_valid  = 1'b1;
    in_a      = 7'h33;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_inv", 32'(out_inv), 32'd0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("midrst_quiet", 32'(out_valid), 32'd0);
    end
    do_op(7'h02, 0, 1'b0, inv, zero, lat);
    chk("post_rst_inv", 32'(inv), 32'h41);

    // All nonzero operands with random consumer stalls.
    results = 0;
    for (int v = 1; v < 128; v++) begin
      do_op(7'(v), int'($urandom_range(0, 3)), 1'b0, inv, zero, lat);
      if (lat < 50) results++;
      chk("sweep_prod", 32'(ref_mul(7'(v), inv)), 32'd1);
      chk("sweep_zero", 32'(zero), 32'd0);
      chk("sweep_lat", 32'(lat), 32'd11);
    end
    chk("sweep_results", 32'(results), 32'd127);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
